instr_fetch_queue: RTL and testbench



---
 rtl/instr_fetch_queue.sv | 137 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch controller with a prefetch queue.
// Reads the combinational big-endian instruction ROM one word per cycle and
// buffers fetched words together with their byte addresses. The issue stage
// drains the queue through a valid/ready handshake. A redirect flushes the
// queue and restarts fetch at a new word-aligned PC.
// Optional feature: define FETCH_HALT_STOP_EN to stop fetching after a halt
// opcode (bits [31:26] == 6'b111111) has been enqueued.
module instr_fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] PC_RESET  = 32'h0,
    parameter int unsigned ROM_BYTES = 100
) (
    input  logic                     clk,
    input  logic                     nrst,
    output logic                     rom_nrd,
    output logic [31:0]              rom_addr,
    input  logic [31:0]              rom_data,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [31:0]              issue_instr,
    output logic [31:0]              issue_pc,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
    localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        END
`ifdef FETCH_HALT_STOP_EN
        , HALT
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     pc;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count;
    logic [31:0]     mem_instr [DEPTH];
    logic [31:0]     mem_pc    [DEPTH];
    logic            fetch;
    logic            deq;
`ifdef FETCH_HALT_STOP_EN
    logic            is_halt;
`endif

    // Fetch/dequeue qualifiers; redirect and reset suppress both.
    always_comb begin
        fetch       = nrst && !redirect && (state == FETCH) && (count < FULL);
        issue_valid = (count != '0);
        deq         = issue_valid && issue_ready && !redirect;
        rom_nrd     = !fetch;
        rom_addr    = pc;
        fq_count    = count;
        issue_instr = issue_valid ? mem_instr[head] : '0;
        issue_pc    = issue_valid ? mem_pc[head]    : '0;
`ifdef FETCH_HALT_STOP_EN
        is_halt     = (rom_data[31:26] == 6'b111111);
`endif
    end

    // Next-state logic; redirect overrides every state.
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (count == FULL) begin
                        state_nxt = WAIT;
`ifdef FETCH_HALT_STOP_EN
                    end else if (is_halt) begin
                        state_nxt = HALT;
`endif
                    end else if (pc == LAST_PC) begin
                        state_nxt = END;
                    end
                end
                WAIT: begin
                    if (count < FULL) begin
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // State, PC, pointer and occupancy registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= FETCH;
            pc    <= PC_RESET;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc    <= redirect_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (fetch) begin
                    pc   <= pc + 32'd4;
                    tail <= tail + 1'b1;
                end
                if (deq) begin
                    head <= head + 1'b1;
                end
                if (fetch && !deq) begin
                    count <= count + 1'b1;
                end else if (!fetch && deq) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Queue storage: capture the ROM word and its address at the tail.
    always_ff @(posedge clk) begin
        if (fetch) begin
            mem_instr[tail] <= rom_data;
            mem_pc[tail]    <= pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed phases plus a random
// phase, compared every cycle against a queue-based reference model.
// Honours FETCH_HALT_STOP_EN in the model when the macro is defined.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] PC_RESET  = 32'h0;
    localparam int unsigned ROM_BYTES = 100;
    localparam logic [31:0] LAST_PC   = 32'(ROM_BYTES - 4);

    logic        clk;
    logic        nrst;
    logic        rom_nrd;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic [2:0]  fq_count;

    logic [8*ROM_BYTES-1:0] romv;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc;
    int          mmode;   // 0 running, 1 waiting for space, 2 ROM end, 3 halted

    instr_fetch_queue #(
        .DEPTH(DEPTH),
        .PC_RESET(PC_RESET),
        .ROM_BYTES(ROM_BYTES)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .rom_nrd(rom_nrd),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_instr(issue_instr),
        .issue_pc(issue_pc),
        .fq_count(fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] romword(input logic [31:0] a,
                                            input logic [8*ROM_BYTES-1:0] v);
        int b;
        if (a > LAST_PC) return '0;
        b = int'(a);
        return v[8*(ROM_BYTES-b)-1 -: 32];
    endfunction

    // Combinational big-endian ROM.
    always_comb rom_data = romword(rom_addr, romv);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc   = PC_RESET;
        mmode = 0;
    endtask

    // One clock cycle: apply inputs, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        int          n;
        logic        f;
        logic        d;
        logic        hlt;
        logic [31:0] w;
        redirect    = rd;
        redirect_pc = rpc;
        issue_ready = rdy;
        @(negedge clk);
        n = q.size();
        f = !rd && (mmode == 0) && (n < DEPTH);
        check("rom_nrd", 32'(rom_nrd), 32'(!f));
        check("rom_addr", rom_addr, mpc);
        check("issue_valid", 32'(issue_valid), 32'(n > 0));
        check("issue_pc", issue_pc, (n > 0) ? q[0].pc : 32'h0);
        check("issue_instr", issue_instr, (n > 0) ? q[0].instr : 32'h0);
        check("fq_count", 32'(fq_count), 32'(n));
        @(posedge clk);
        if (rd) begin
            q.delete();
            mpc   = rpc;
            mmode = 0;
        end else begin
            d = (n > 0) && rdy;
            w = romword(mpc, romv);
            if (d) void'(q.pop_front());
            if (f) q.push_back('{pc: mpc, instr: w});
            if (mmode == 0) begin
                if (n >= DEPTH) begin
                    mmode = 1;
                end else begin
                    hlt = 1'b0;
`ifdef FETCH_HALT_STOP_EN
                    hlt = (w[31:26] == 6'b111111);
`endif
                    if (hlt) mmode = 3;
                    else if (mpc == LAST_PC) mmode = 2;
                    mpc = mpc + 32'd4;
                end
            end else if (mmode == 1 && n < DEPTH) begin
                mmode = 0;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        logic [7:0] b;
        // ROM contents: only the word at address 8 carries the halt opcode.
        for (int i = 0; i < ROM_BYTES; i++) begin
            b = 8'($urandom);
            if (i == 8) b = 8'hFC | 8'($urandom_range(0, 3));
            else if ((i % 4) == 0 && b[7:2] == 6'b111111) b[7] = 1'b0;
            romv[8*(ROM_BYTES-i)-1 -: 8] = b;
        end
        nrst        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        issue_ready = 1'b0;
        model_reset();

        // Outputs while held in reset.
        @(negedge clk);
        check("rst_rom_nrd", 32'(rom_nrd), 32'h1);
        check("rst_rom_addr", rom_addr, PC_RESET);
        check("rst_issue_valid", 32'(issue_valid), 32'h0);
        check("rst_issue_instr", issue_instr, 32'h0);
        check("rst_issue_pc", issue_pc, 32'h0);
        check("rst_fq_count", 32'(fq_count), 32'h0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // Steady stream with the issue stage always ready.
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

        // Backpressure: fill, wait, drain one, refill.
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);

        // Redirect while full.
        step(1'b1, 32'h20, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // ROM end, then resume from 0.
        step(1'b1, 32'd88, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);

        // Halt word at 8 with a slow consumer.
        step(1'b1, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'($urandom_range(0, 1)));

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0)
                step(1'b1, 32'($urandom_range(0, (ROM_BYTES - 4) / 4)) * 32'd4,
                     1'($urandom_range(0, 1)));
            else
                step(1'b0, 32'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-stream with a non-empty queue.
        step(1'b1, 32'h10, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_issue_valid", 32'(issue_valid), 32'h0);
        check("arst_rom_nrd", 32'(rom_nrd), 32'h1);
        check("arst_fq_count", 32'(fq_count), 32'h0);
        check("arst_rom_addr", rom_addr, PC_RESET);
        check("arst_issue_pc", issue_pc, 32'h0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
